psg_bus_sequencer: RTL and testbench

- Bus initiator for an AY-3-8913/YM2149 PSG: the sequencing a 6522 port A/B pair does under Mockingboard driver software, done in hardware.
- Takes register-level requests (write, read, chip reset) and emits the BDIR/BC/DA/RESET handshake, pacing each bus phase to a bus-rate enable strobe.
- Sits between a host-side request source (player FSM, test/diagnostic engine) and a YM2149 core instance.

---
 rtl/psg_bus_sequencer_if.sv | 31 +++
 rtl/psg_bus_sequencer.sv | 125 ++++++++++++
 tb/tb_psg_bus_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psg_bus_sequencer_if.sv
// Request and PSG bus signals between a host-side sequencer and a YM2149 core.
// The master modport is the sequencer's view; slave is the environment's.
`timescale 1ns/1ps
interface psg_bus_sequencer_if;
  logic       ce_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [1:0] req_op_i;
  logic [3:0] req_reg_i;
  logic [7:0] req_data_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_data_o;
  logic [7:0] psg_da_o;
  logic [7:0] psg_da_i;
  logic       psg_bdir_o;
  logic       psg_bc_o;
  logic       psg_reset_n_o;
  logic       busy_o;

  modport master (
    input  ce_i, req_valid_i, req_op_i, req_reg_i, req_data_i, psg_da_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, psg_da_o, psg_bdir_o,
           psg_bc_o, psg_reset_n_o, busy_o
  );

  modport slave (
    output ce_i, req_valid_i, req_op_i, req_reg_i, req_data_i, psg_da_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, psg_da_o, psg_bdir_o,
           psg_bc_o, psg_reset_n_o, busy_o
  );
endinterface

// File: rtl/psg_bus_sequencer.sv
// AY-3-8913/YM2149 bus initiator: turns register-level requests into the
// BDIR/BC/DA/RESET handshake, pacing every bus phase to the ce_i strobe.
`timescale 1ns/1ps
module psg_bus_sequencer #(
  parameter int unsigned PHASE_CE = 1,
  parameter int unsigned RESET_CE = 4
) (
  input  logic           clk_logic,
  input  logic           system_reset_n,
  psg_bus_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_INACT1, S_WRITE, S_READ, S_INACT2, S_RST
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00, OP_READ = 2'b01, OP_RESET = 2'b10, OP_NOP = 2'b11
  } op_t;

  localparam logic [3:0] PH_LAST  = 4'(PHASE_CE - 1);
  localparam logic [3:0] RST_LAST = 4'(RESET_CE - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  op_t        op;
  logic [3:0] reg_idx;
  logic [7:0] data;
  logic       released, released_nxt;
  logic       accept, phase_done;

  logic       ready_r, busy_r, rsp_valid_r, bdir_r, bc_r, reset_n_r;
  logic [7:0] rsp_data_r, da_r;

  always_comb begin
    accept       = bus.req_valid_i && (state == S_IDLE);
    phase_done   = bus.ce_i && (cnt == ((state == S_RST) ? RST_LAST : PH_LAST));
    released_nxt = released | accept;
    state_nxt    = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (op_t'(bus.req_op_i))
            OP_WRITE, OP_READ: state_nxt = S_LATCH;
            OP_RESET:          state_nxt = S_RST;
            OP_NOP:            state_nxt = S_INACT2;
          endcase
        end
      end
      S_LATCH:  if (phase_done) state_nxt = S_INACT1;
      S_INACT1: if (phase_done) state_nxt = (op == OP_READ) ? S_READ : S_WRITE;
      S_WRITE,
      S_READ,
      S_RST:    if (phase_done) state_nxt = S_INACT2;
      S_INACT2: if (phase_done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are valid for the whole state.
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op          <= OP_WRITE;
      reg_idx     <= '0;
      data        <= '0;
      released    <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      da_r        <= '0;
      bdir_r      <= 1'b0;
      bc_r        <= 1'b0;
      reset_n_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (bus.ce_i && state != S_IDLE)
        cnt <= cnt + 4'd1;

      if (accept) begin
        op      <= op_t'(bus.req_op_i);
        reg_idx <= bus.req_reg_i;
        data    <= bus.req_data_i;
      end

      if (state == S_READ && phase_done)
        rsp_data_r <= bus.psg_da_i;

      released    <= released_nxt;
      rsp_valid_r <= (state != S_IDLE) && (state_nxt == S_IDLE);
      ready_r     <= (state_nxt == S_IDLE);
      busy_r      <= (state_nxt != S_IDLE);
      reset_n_r   <= released_nxt && (state_nxt != S_RST);

      bdir_r <= 1'b0;
      bc_r   <= 1'b0;
      da_r   <= '0;
      unique case (state_nxt)
        S_LATCH: begin bdir_r <= 1'b1; bc_r <= 1'b1; da_r <= {4'h0, reg_nxt_sel()}; end
        S_WRITE: begin bdir_r <= 1'b1; da_r <= data; end
        S_READ:  bc_r <= 1'b1;
        default: ;
      endcase
    end
  end

  // LATCH is entered straight from IDLE, before reg_idx holds the new index.
  function automatic logic [3:0] reg_nxt_sel();
    return accept ? bus.req_reg_i : reg_idx;
  endfunction

  assign bus.req_ready_o   = ready_r;
  assign bus.busy_o        = busy_r;
  assign bus.rsp_valid_o   = rsp_valid_r;
  assign bus.rsp_data_o    = rsp_data_r;
  assign bus.psg_da_o      = da_r;
  assign bus.psg_bdir_o    = bdir_r;
  assign bus.psg_bc_o      = bc_r;
  assign bus.psg_reset_n_o = reset_n_r;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Bench for psg_bus_sequencer: directed and random requests against a per-op
// phase-list model, a PSG register-file model, and a ce-paced second instance.
`timescale 1ns/1ps
module tb_psg_bus_sequencer;

  typedef struct packed {
    logic       bdir;
    logic       bc;
    logic [7:0] da;
    logic       rstn;
  } bus_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  psg_bus_sequencer_if ifa ();
  psg_bus_sequencer_if ifb ();

  psg_bus_sequencer #(.PHASE_CE(1), .RESET_CE(4)) dut_a (
    .clk_logic(clk), .system_reset_n(rst_n), .bus(ifa)
  );
  psg_bus_sequencer #(.PHASE_CE(2), .RESET_CE(4)) dut_b (
    .clk_logic(clk), .system_reset_n(rst_n), .bus(ifb)
  );

  // Behavioural YM2149 register file hanging off dut_a's bus.
  logic [7:0] psg_regs [16];
  logic [3:0] psg_addr;
  always @(posedge clk) begin
    if (!ifa.psg_reset_n_o) begin
      for (int i = 0; i < 16; i++) psg_regs[i] <= '0;
      psg_addr <= '0;
    end else if (ifa.psg_bdir_o && ifa.psg_bc_o)
      psg_addr <= ifa.psg_da_o[3:0];
    else if (ifa.psg_bdir_o && !ifa.psg_bc_o)
      psg_regs[psg_addr] <= ifa.psg_da_o;
  end
  assign ifa.psg_da_i = (!ifa.psg_bdir_o && ifa.psg_bc_o) ? psg_regs[psg_addr] : 8'hEE;
  assign ifb.psg_da_i = 8'h00;

  logic [7:0] shadow [16];
  logic [7:0] exp_rsp;
  bus_t       exp_q [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_n(input bus_t b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endfunction

  // Expected per-clk bus state for dut_a (ce tied high): each phase lasts N clks.
  function automatic void build(input logic [1:0] op, input logic [3:0] r, input logic [7:0] d);
    exp_q.delete();
    case (op)
      2'b00: begin
        push_n('{1'b1, 1'b1, {4'h0, r}, 1'b1}, 1);
        push_n('{1'b0, 1'b0, 8'h00, 1'b1}, 1);
        push_n('{1'b1, 1'b0, d, 1'b1}, 1);
        push_n('{1'b0, 1'b0, 8'h00, 1'b1}, 1);
      end
      2'b01: begin
        push_n('{1'b1, 1'b1, {4'h0, r}, 1'b1}, 1);
        push_n('{1'b0, 1'b0, 8'h00, 1'b1}, 1);
        push_n('{1'b0, 1'b1, 8'h00, 1'b1}, 1);
        push_n('{1'b0, 1'b0, 8'h00, 1'b1}, 1);
      end
      2'b10: begin
        push_n('{1'b0, 1'b0, 8'h00, 1'b0}, 4);
        push_n('{1'b0, 1'b0, 8'h00, 1'b1}, 1);
      end
      default: push_n('{1'b0, 1'b0, 8'h00, 1'b1}, 1);
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [3:0] r, input logic [7:0] d, input bit keep);
    bus_t e;
    ifa.req_valid_i = 1'b1;
    ifa.req_op_i    = op;
    ifa.req_reg_i   = r;
    ifa.req_data_i  = d;
    chk("ready_before_accept", ifa.req_ready_o, 1);
    build(op, r, d);
    step();
    if (keep) begin
      ifa.req_op_i   = 2'($urandom_range(0, 3));
      ifa.req_reg_i  = 4'($urandom);
      ifa.req_data_i = 8'($urandom);
    end else
      ifa.req_valid_i = 1'b0;
    case (op)
      2'b00: shadow[r] = d;
      2'b01: exp_rsp = shadow[r];
      2'b10: for (int i = 0; i < 16; i++) shadow[i] = '0;
      default: ;
    endcase
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("bdir", ifa.psg_bdir_o, e.bdir);
      chk("bc", ifa.psg_bc_o, e.bc);
      chk("da", ifa.psg_da_o, e.da);
      chk("psg_reset_n", ifa.psg_reset_n_o, e.rstn);
      chk("ready_in_seq", ifa.req_ready_o, 0);
      chk("busy_in_seq", ifa.busy_o, 1);
      chk("rsp_valid_early", ifa.rsp_valid_o, 0);
      step();
    end
    chk("rsp_valid_done", ifa.rsp_valid_o, 1);
    chk("ready_done", ifa.req_ready_o, 1);
    chk("busy_done", ifa.busy_o, 0);
    chk("bdir_done", ifa.psg_bdir_o, 0);
    chk("bc_done", ifa.psg_bc_o, 0);
    chk("da_done", ifa.psg_da_o, 8'h00);
    chk("psg_reset_n_done", ifa.psg_reset_n_o, 1);
    chk("rsp_data", ifa.rsp_data_o, exp_rsp);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("gap_rsp_valid", ifa.rsp_valid_o, 0);
      chk("gap_ready", ifa.req_ready_o, 1);
      chk("gap_bdir_bc", {ifa.psg_bdir_o, ifa.psg_bc_o}, 2'b00);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, ifa.req_ready_o, 1);
    chk({tag, "_busy"}, ifa.busy_o, 0);
    chk({tag, "_rsp_valid"}, ifa.rsp_valid_o, 0);
    chk({tag, "_rsp_data"}, ifa.rsp_data_o, 8'h00);
    chk({tag, "_da"}, ifa.psg_da_o, 8'h00);
    chk({tag, "_bdir_bc"}, {ifa.psg_bdir_o, ifa.psg_bc_o}, 2'b00);
    chk({tag, "_psg_reset_n"}, ifa.psg_reset_n_o, 0);
  endtask

  initial begin
    logic [1:0] rop;
    bit         keep, done;
    int         k, ph;
    bus_t       wr_tab [4];

    rst_n = 1'b0;
    ifa.ce_i = 1'b1; ifa.req_valid_i = 1'b0; ifa.req_op_i = '0; ifa.req_reg_i = '0; ifa.req_data_i = '0;
    ifb.ce_i = 1'b0; ifb.req_valid_i = 1'b0; ifb.req_op_i = '0; ifb.req_reg_i = '0; ifb.req_data_i = '0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    exp_rsp = '0;

    step(); step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    idle_gap(3);
    chk("powerup_hold", ifa.psg_reset_n_o, 0);

    // Directed: write/read, rsp_data retention, chip reset, no-op.
    run_op(2'b00, 4'h7, 8'h38, 1'b0);
    idle_gap(1);
    run_op(2'b00, 4'h8, 8'h5A, 1'b0);
    run_op(2'b01, 4'h8, 8'h00, 1'b0);
    run_op(2'b00, 4'h3, 8'h11, 1'b0);
    idle_gap(2);
    run_op(2'b10, 4'h0, 8'h00, 1'b0);
    run_op(2'b11, 4'hF, 8'hFF, 1'b0);
    run_op(2'b01, 4'h8, 8'h00, 1'b0);

    // Random ops; keep holds valid high with junk fields to force back-to-back accepts.
    for (int n = 0; n < 40; n++) begin
      rop  = 2'($urandom_range(0, 3));
      keep = (n != 39) && ($urandom_range(0, 1) == 1);
      run_op(rop, 4'($urandom), 8'($urandom), keep);
      if (!keep) idle_gap($urandom_range(1, 3));
    end

    // Pacing on dut_b: PHASE_CE=2, ce every 4th clk; phase index = ce pulses / 2.
    wr_tab[0] = '{1'b1, 1'b1, 8'h05, 1'b1};
    wr_tab[1] = '{1'b0, 1'b0, 8'h00, 1'b1};
    wr_tab[2] = '{1'b1, 1'b0, 8'hA7, 1'b1};
    wr_tab[3] = '{1'b0, 1'b0, 8'h00, 1'b1};
    ifb.req_valid_i = 1'b1; ifb.req_op_i = 2'b00; ifb.req_reg_i = 4'h5; ifb.req_data_i = 8'hA7;
    ifb.ce_i = 1'b0;
    chk("pace_ready", ifb.req_ready_o, 1);
    step();
    ifb.req_valid_i = 1'b0;
    k = 0; done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      ifb.ce_i = (i % 4 == 3);
      step();
      if (ifb.ce_i) k++;
      ph = k / 2;
      if (ph < 4) begin
        chk("pace_bdir", ifb.psg_bdir_o, wr_tab[ph].bdir);
        chk("pace_bc", ifb.psg_bc_o, wr_tab[ph].bc);
        chk("pace_da", ifb.psg_da_o, wr_tab[ph].da);
        chk("pace_rsp_early", ifb.rsp_valid_o, 0);
        chk("pace_ready_low", ifb.req_ready_o, 0);
      end else begin
        chk("pace_rsp_valid", ifb.rsp_valid_o, 1);
        chk("pace_ready_done", ifb.req_ready_o, 1);
        done = 1'b1;
      end
    end
    if (!done) chk("pace_timeout", 0, 1);
    ifb.ce_i = 1'b0;
    step();
    chk("pace_rsp_pulse_width", ifb.rsp_valid_o, 0);

    // Abort during WRITE: reset values next clk, no completion, hold re-armed.
    ifa.req_valid_i = 1'b1; ifa.req_op_i = 2'b00; ifa.req_reg_i = 4'h2; ifa.req_data_i = 8'h99;
    step();
    ifa.req_valid_i = 1'b0;
    step(); step();
    chk("abort_in_write_bdir_bc", {ifa.psg_bdir_o, ifa.psg_bc_o}, 2'b10);
    chk("abort_in_write_da", ifa.psg_da_o, 8'h99);
    rst_n = 1'b0;
    step();
    chk_reset_vals("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    exp_rsp = '0;
    idle_gap(3);
    chk("abort_hold", ifa.psg_reset_n_o, 0);
    run_op(2'b01, 4'h2, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
